// File: rtl/bht_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bht_port_arbiter: shares a single-port BHT between lookups and queued updates |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module bht_port_arbiter #(
  parameter int M         = 16,
  parameter int N         = 2,
  parameter int PC_W      = 9,
  parameter int QDEPTH    = 4,
  parameter int MAX_DEFER = 3,
  localparam int IDX_W    = $clog2(M)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lu_valid,
  input  logic [PC_W-1:0]  lu_pc,
  output logic             lu_ready,
  output logic             pred_valid,
  output logic             prediction,
  input  logic             up_valid,
  input  logic [PC_W-1:0]  up_pc,
  input  logic             up_taken,
  output logic             up_ready,
  output logic             init_done,
  output logic             mem_en,
  output logic             mem_we,
  output logic [IDX_W-1:0] mem_addr,
  output logic [N-1:0]     mem_wdata,
  input  logic [N-1:0]     mem_rdata
);

  localparam int c_PTR_W = $clog2(QDEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_DEF_W = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam logic [N-1:0] c_INIT_VAL = N'((1 << (N - 1)) - 1);
  localparam logic [1:0] c_INIT   = 2'd0;
  localparam logic [1:0] c_RUN    = 2'd1;
  localparam logic [1:0] c_UPD_WR = 2'd2;

  logic [1:0]         r_state, w_next_state;
  logic [IDX_W-1:0]   r_init_cnt;
  logic [IDX_W-1:0]   r_fifo_idx [QDEPTH];
  logic               r_fifo_taken [QDEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_DEF_W-1:0] r_defer;
  logic [IDX_W-1:0]   r_hold_idx;
  logic               r_hold_taken;
  logic               r_pend, r_pred_last, r_init_done;

  logic             w_nonempty, w_full, w_lu_ok, w_run;
  logic             w_lu_grant, w_upd_issue, w_push;
  logic             w_mem_en, w_mem_we;
  logic [IDX_W-1:0] w_mem_addr;
  logic [N-1:0]     w_mem_wdata, w_sat;
  logic             w_unused_pc_hi;

  assign w_nonempty  = (r_count != '0);
  assign w_full      = (r_count == c_CNT_W'(QDEPTH));
  assign w_lu_ok     = !(w_nonempty && (w_full || (r_defer == c_DEF_W'(MAX_DEFER))));
  assign w_run       = (r_state == c_RUN);
  assign w_lu_grant  = w_run && lu_valid && w_lu_ok;
  assign w_upd_issue = w_run && !w_lu_grant && w_nonempty;
  assign w_push      = up_valid && up_ready;

  assign lu_ready   = w_run && w_lu_ok;
  assign up_ready   = (r_state != c_INIT) && !w_full;
  assign pred_valid = r_pend;
  assign prediction = r_pend ? mem_rdata[N-1] : r_pred_last;
  assign init_done  = r_init_done;

  // Table port is forced idle while reset is held so no sweep write escapes.
  assign mem_en    = reset && w_mem_en;
  assign mem_we    = reset && w_mem_we;
  assign mem_addr  = reset ? w_mem_addr : '0;
  assign mem_wdata = reset ? w_mem_wdata : '0;

  assign w_unused_pc_hi = &{1'b0, lu_pc[PC_W-1:IDX_W], up_pc[PC_W-1:IDX_W]};

  always_comb begin
    w_sat = mem_rdata;
    if (r_hold_taken) begin
      if (mem_rdata != '1) w_sat = mem_rdata + N'(1);
    end else begin
      if (mem_rdata != '0) w_sat = mem_rdata - N'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_INIT;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_INIT:   if (r_init_cnt == IDX_W'(M - 1)) w_next_state = c_RUN;
      c_RUN:    if (w_upd_issue) w_next_state = c_UPD_WR;
      c_UPD_WR: w_next_state = c_RUN;
      default:  w_next_state = c_INIT;
    endcase
  end

  always_comb begin
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      c_INIT: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_init_cnt;
        w_mem_wdata = c_INIT_VAL;
      end
      c_RUN: begin
        if (w_lu_grant) begin
          w_mem_en   = 1'b1;
          w_mem_addr = lu_pc[IDX_W-1:0];
        end else if (w_nonempty) begin
          w_mem_en   = 1'b1;
          w_mem_addr = r_fifo_idx[r_rd_ptr];
        end
      end
      c_UPD_WR: begin
        w_mem_en    = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = r_hold_idx;
        w_mem_wdata = w_sat;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_init_cnt   <= '0;
      r_init_done  <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_defer      <= '0;
      r_hold_idx   <= '0;
      r_hold_taken <= 1'b0;
      r_pend       <= 1'b0;
      r_pred_last  <= 1'b0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_fifo_idx[i]   <= '0;
        r_fifo_taken[i] <= 1'b0;
      end
    end else begin
      if (r_state == c_INIT) begin
        r_init_cnt <= r_init_cnt + IDX_W'(1);
        if (r_init_cnt == IDX_W'(M - 1)) r_init_done <= 1'b1;
      end
      if (w_push) begin
        r_fifo_idx[r_wr_ptr]   <= up_pc[IDX_W-1:0];
        r_fifo_taken[r_wr_ptr] <= up_taken;
        r_wr_ptr               <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_upd_issue) begin
        r_hold_idx   <= r_fifo_idx[r_rd_ptr];
        r_hold_taken <= r_fifo_taken[r_rd_ptr];
        r_rd_ptr     <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_upd_issue})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: ;
      endcase
      // Defer only accumulates while an update is actually waiting.
      if (!w_nonempty || w_upd_issue) r_defer <= '0;
      else if (w_lu_grant)            r_defer <= r_defer + c_DEF_W'(1);
      r_pend <= w_lu_grant;
      if (r_pend) r_pred_last <= mem_rdata[N-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bht_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bht_port_arbiter: directed scoreboard bench for bht_port_arbiter        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_bht_port_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       lu_valid, lu_ready, pred_valid, prediction;
  logic [8:0] lu_pc, up_pc;
  logic       up_valid, up_taken, up_ready, init_done;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata = 2'b00;

  logic [1:0] tbmem [16];
  logic [1:0] mdl [16];
  bit         sb_pred [$];
  logic [5:0] sb_wr [$];
  int         n_cmp = 0;
  int         n_fail = 0;

  bht_port_arbiter dut (
    .clk(clk), .reset(reset),
    .lu_valid(lu_valid), .lu_pc(lu_pc), .lu_ready(lu_ready),
    .pred_valid(pred_valid), .prediction(prediction),
    .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken), .up_ready(up_ready),
    .init_done(init_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port table with registered read data.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tbmem[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sat(input logic [1:0] c, input bit t);
    if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic exp_update(input int idx, input bit t);
    mdl[idx] = sat(mdl[idx], t);
    sb_wr.push_back({idx[3:0], mdl[idx]});
  endtask

  task automatic sweep_check();
    for (int i = 0; i < 16; i++) begin
      chk("init_wr", {mem_en, mem_we, mem_addr, mem_wdata, init_done, lu_ready, up_ready},
          {1'b1, 1'b1, i[3:0], 2'b01, 1'b0, 1'b0, 1'b0});
      @(negedge clk); #1;
    end
    chk("init_done", init_done, 1);
    chk("run_idle", {mem_en, up_ready, lu_ready}, 3'b011);
    for (int i = 0; i < 16; i++) mdl[i] = 2'b01;
  endtask

  // Scoreboard consumers: predictions and table writes in RUN.
  always @(negedge clk) begin
    logic [5:0] ew;
    bit         ep;
    if (reset) begin
      if (pred_valid) begin
        if (sb_pred.size() == 0) chk("pred_spurious", pred_valid, 0);
        else begin
          ep = sb_pred.pop_front();
          chk("pred", prediction, ep);
        end
      end
      if (init_done && mem_en && mem_we) begin
        if (sb_wr.size() == 0) chk("wr_spurious", {mem_we, mem_addr, mem_wdata}, 0);
        else begin
          ew = sb_wr.pop_front();
          chk("wr", {mem_addr, mem_wdata}, ew);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    lu_valid = 0; lu_pc = 0; up_valid = 0; up_pc = 0; up_taken = 0; reset = 1;
    #2 reset = 0;
    @(negedge clk); #1;
    chk("rst_outs", {lu_ready, up_ready, pred_valid, prediction, init_done, mem_en, mem_we,
                     mem_addr, mem_wdata}, 0);
    @(negedge clk); reset = 1; #1;
    sweep_check();

    // Single lookup, index 3
    @(negedge clk); lu_valid = 1; lu_pc = 9'h1A3; #1;
    chk("t2_read", {lu_ready, mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 1'b0, 4'd3});
    sb_pred.push_back(mdl[3][1]);
    @(negedge clk); lu_valid = 0; #1;
    chk("t2_pv", pred_valid, 1);

    // Three taken updates to index 5, then look it up
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); up_valid = 1; up_pc = 9'h005; up_taken = 1; #1;
      chk("t3_up_ready", up_ready, 1);
      exp_update(5, 1);
    end
    @(negedge clk); up_valid = 0;
    repeat (5) @(negedge clk);
    #1;
    chk("t3_drained", sb_wr.size(), 0);
    lu_valid = 1; lu_pc = 9'h005; #1;
    chk("t3_lu_ready", lu_ready, 1);
    sb_pred.push_back(mdl[5][1]);
    @(negedge clk); lu_valid = 0; #1;
    chk("t3_pv", pred_valid, 1);
    @(negedge clk); #1;
    chk("t3_hold", {pred_valid, prediction}, 2'b01);

    // Defer bound: lookups stream while one update waits
    @(negedge clk); up_valid = 1; up_pc = 9'h00A; up_taken = 0; #1;
    exp_update(10, 0);
    @(negedge clk); up_valid = 0; lu_valid = 1; lu_pc = 9'h105;
    for (int k = 0; k < 6; k++) begin
      bit er;
      er = (k < 3) || (k == 5);
      #1;
      chk("t4_lu_ready", lu_ready, er);
      if (er) sb_pred.push_back(mdl[5][1]);
      @(negedge clk);
    end

    // Fill the FIFO while lookups block the drain
    lu_pc = 9'h0F5; up_valid = 1; up_pc = 9'h007; up_taken = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t5_rdy", {up_ready, lu_ready}, 2'b11);
      exp_update(7, 1);
      sb_pred.push_back(mdl[5][1]);
      @(negedge clk);
    end
    up_valid = 0; lu_valid = 0; #1;
    chk("t5_full", {up_ready, lu_ready}, 2'b00);
    @(negedge clk); #1;
    chk("t5_pop", {up_ready, lu_ready}, 2'b10);
    repeat (8) @(negedge clk);
    #1;
    chk("t5_drained", sb_wr.size(), 0);

    // Reset in the middle of a read-modify-write with two updates queued
    @(negedge clk); lu_valid = 1; lu_pc = 9'h000; up_valid = 1; up_pc = 9'h009; up_taken = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_lu_ready", lu_ready, 1);
      sb_pred.push_back(mdl[0][1]);
      @(negedge clk);
    end
    lu_valid = 0; up_valid = 0; #1;
    chk("t6_issue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 4'd9});
    @(posedge clk); #1;
    chk("t6_upd_wr", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 4'd9});
    #1 reset = 0; #1;
    chk("t6_rst", {lu_ready, up_ready, pred_valid, prediction, init_done, mem_en, mem_we,
                   mem_addr, mem_wdata}, 0);
    repeat (2) @(negedge clk);
    reset = 1; #1;
    sweep_check();
    @(negedge clk); lu_valid = 1; lu_pc = 9'h009; #1;
    chk("t6_lu9", lu_ready, 1);
    sb_pred.push_back(mdl[9][1]);
    @(negedge clk); lu_pc = 9'h007; #1;
    chk("t6_lu7", lu_ready, 1);
    sb_pred.push_back(mdl[7][1]);
    @(negedge clk); lu_valid = 0;
    repeat (4) @(negedge clk);
    #1;
    chk("sb_pred_empty", sb_pred.size(), 0);
    chk("sb_wr_empty", sb_wr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
